tage_tagged_bank: RTL and testbench

One tagged TAGE predictor table. It consumes the index/tag pair produced by the index/tag generator and answers a lookup with hit, counter and useful-bit state. It also accepts training, allocation and useful-bit updates from the update logic. The block self-initialises after reset and periodically ages the useful bits by sweeping the table.

---
 rtl/tage_tagged_bank_if.sv | 37 +++
 rtl/tage_tagged_bank.sv | 190 +++++++++++++++++++
 tb/tb_tage_tagged_bank.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tage_tagged_bank_if.sv
// Lookup and update bus of one tagged TAGE bank.
// The master drives requests and the bank (slave) returns the response.
interface tage_tagged_bank_if #(
    parameter int IL      = 10,
    parameter int TAG_LEN = 8,
    parameter int CTR_W   = 3,
    parameter int U_W     = 2
);
    logic               ready;
    logic               lookup_valid;
    logic [IL-1:0]      lookup_index;
    logic [TAG_LEN-1:0] lookup_tag;
    logic               pred_valid;
    logic               pred_hit;
    logic               pred_taken;
    logic               pred_weak;
    logic [CTR_W-1:0]   pred_ctr;
    logic [U_W-1:0]     pred_u;
    logic               upd_valid;
    logic [1:0]         upd_op;
    logic [IL-1:0]      upd_index;
    logic [TAG_LEN-1:0] upd_tag;
    logic               upd_taken;
    logic               upd_ignored;

    modport master (
        input  ready, pred_valid, pred_hit, pred_taken, pred_weak, pred_ctr, pred_u, upd_ignored,
        output lookup_valid, lookup_index, lookup_tag,
        output upd_valid, upd_op, upd_index, upd_tag, upd_taken
    );

    modport slave (
        output ready, pred_valid, pred_hit, pred_taken, pred_weak, pred_ctr, pred_u, upd_ignored,
        input  lookup_valid, lookup_index, lookup_tag,
        input  upd_valid, upd_op, upd_index, upd_tag, upd_taken
    );
endinterface

// File: rtl/tage_tagged_bank.sv
// One tagged TAGE table: registered lookup, in-place training/allocation,
// self-initialising sweep after reset and periodic useful-bit aging sweep.
module tage_tagged_bank #(
    parameter int IL      = 10,
    parameter int TAG_LEN = 8,
    parameter int CTR_W   = 3,
    parameter int U_W     = 2,
    parameter int AGE_LOG = 18
) (
    input  logic                    CLK,
    input  logic                    reset,
    tage_tagged_bank_if.slave       bus
);
    localparam int               DEPTH   = 1 << IL;
    localparam logic [IL-1:0]    LAST    = '1;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MID = {1'b1, {(CTR_W-1){1'b0}}};  // weakly taken
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};  // weakly not-taken
    localparam logic [U_W-1:0]   U_MAX   = '1;

    localparam logic [1:0] OP_TRAIN = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_UINC  = 2'b10;
    localparam logic [1:0] OP_UDEC  = 2'b11;

    typedef struct packed {
        logic               vld;
        logic [TAG_LEN-1:0] tag;
        logic [CTR_W-1:0]   ctr;
        logic [U_W-1:0]     u;
    } entry_t;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_AGE} state_t;

    state_t             r_state, w_next_state;
    logic [IL-1:0]      r_sweep_ptr;
    logic [AGE_LOG-1:0] r_age_cnt;
    logic               r_ready;
    entry_t             r_tbl [DEPTH];

    logic               r_pred_valid, r_pred_hit, r_pred_taken, r_pred_weak;
    logic [CTR_W-1:0]   r_pred_ctr;
    logic [U_W-1:0]     r_pred_u;
    logic               r_upd_ignored;

    logic               w_lkp_acc, w_upd_acc, w_lkp_hit, w_match, w_age_wrap, w_sweep_done;
    logic               w_upd_we, w_upd_ign;
    entry_t             w_lkp_ent, w_upd_ent, w_upd_new;

    // ready mirrors state==IDLE, so it doubles as the accept gate
    assign w_lkp_acc    = bus.lookup_valid & r_ready;
    assign w_upd_acc    = bus.upd_valid & r_ready;
    assign w_lkp_ent    = r_tbl[bus.lookup_index];
    assign w_upd_ent    = r_tbl[bus.upd_index];
    assign w_lkp_hit    = w_lkp_ent.vld && (w_lkp_ent.tag == bus.lookup_tag);
    assign w_match      = w_upd_ent.vld && (w_upd_ent.tag == bus.upd_tag);
    assign w_age_wrap   = w_upd_acc && (r_age_cnt == '1);
    assign w_sweep_done = (r_sweep_ptr == LAST);

    // New entry contents for an update request, and whether it took effect
    always_comb begin
        w_upd_new = w_upd_ent;
        w_upd_we  = 1'b0;
        w_upd_ign = 1'b0;
        case (bus.upd_op)
            OP_TRAIN: begin
                if (w_match) begin
                    w_upd_we = 1'b1;
                    if (bus.upd_taken) begin
                        if (w_upd_ent.ctr != CTR_MAX) w_upd_new.ctr = w_upd_ent.ctr + 1'b1;
                    end else begin
                        if (w_upd_ent.ctr != '0) w_upd_new.ctr = w_upd_ent.ctr - 1'b1;
                    end
                end else begin
                    w_upd_ign = 1'b1;
                end
            end
            OP_ALLOC: begin
                w_upd_we = 1'b1;
                if (w_upd_ent.u == '0) begin
                    w_upd_new = '{vld: 1'b1, tag: bus.upd_tag,
                                  ctr: bus.upd_taken ? CTR_MID : CTR_WNT, u: '0};
                end else begin
                    // a useful victim is only worn down, never replaced
                    w_upd_new.u = w_upd_ent.u - 1'b1;
                    w_upd_ign   = 1'b1;
                end
            end
            OP_UINC: begin
                if (w_match) begin
                    w_upd_we = 1'b1;
                    if (w_upd_ent.u != U_MAX) w_upd_new.u = w_upd_ent.u + 1'b1;
                end else begin
                    w_upd_ign = 1'b1;
                end
            end
            OP_UDEC: begin
                if (w_match) begin
                    w_upd_we = 1'b1;
                    if (w_upd_ent.u != '0) w_upd_new.u = w_upd_ent.u - 1'b1;
                end else begin
                    w_upd_ign = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next state: sweeps end at the last row, aging starts on counter wrap
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:  if (w_sweep_done) w_next_state = S_IDLE;
            S_IDLE:  if (w_age_wrap)   w_next_state = S_AGE;
            S_AGE:   if (w_sweep_done) w_next_state = S_IDLE;
            default: w_next_state = S_INIT;
        endcase
    end

    // State register and registered ready (tracks next state so it equals state==IDLE)
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == S_IDLE);
        end
    end

    // Sweep pointer runs during INIT/AGE and wraps to 0 exactly as the sweep ends
    always_ff @(posedge CLK) begin
        if (!reset || r_state == S_IDLE) r_sweep_ptr <= '0;
        else                             r_sweep_ptr <= r_sweep_ptr + 1'b1;
    end

    // Count accepted updates towards the next aging sweep
    always_ff @(posedge CLK) begin
        if (!reset)         r_age_cnt <= '0;
        else if (w_upd_acc) r_age_cnt <= r_age_cnt + 1'b1;
    end

    // Table writes: init sweep, aging sweep, or a single update in IDLE
    always_ff @(posedge CLK) begin
        if (reset) begin
            case (r_state)
                S_INIT:  r_tbl[r_sweep_ptr] <= '{vld: 1'b0, tag: '0, ctr: CTR_WNT, u: '0};
                S_AGE:   r_tbl[r_sweep_ptr].u <= r_tbl[r_sweep_ptr].u >> 1;
                S_IDLE:  if (w_upd_acc && w_upd_we) r_tbl[bus.upd_index] <= w_upd_new;
                default: ;
            endcase
        end
    end

    // Lookup response register; fields hold when no lookup is accepted
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_pred_valid <= 1'b0;
            r_pred_hit   <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_weak  <= 1'b0;
            r_pred_ctr   <= '0;
            r_pred_u     <= '0;
        end else begin
            r_pred_valid <= w_lkp_acc;
            if (w_lkp_acc) begin
                r_pred_hit   <= w_lkp_hit;
                r_pred_taken <= w_lkp_hit && w_lkp_ent.ctr[CTR_W-1];
                r_pred_weak  <= w_lkp_hit && (w_lkp_ent.ctr == CTR_WNT || w_lkp_ent.ctr == CTR_MID);
                r_pred_ctr   <= w_lkp_hit ? w_lkp_ent.ctr : '0;
                r_pred_u     <= w_lkp_ent.u;
            end
        end
    end

    // One-cycle pulse for an accepted update that did not take effect
    always_ff @(posedge CLK) begin
        if (!reset) r_upd_ignored <= 1'b0;
        else        r_upd_ignored <= w_upd_acc & w_upd_ign;
    end

    assign bus.ready       = r_ready;
    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_hit    = r_pred_hit;
    assign bus.pred_taken  = r_pred_taken;
    assign bus.pred_weak   = r_pred_weak;
    assign bus.pred_ctr    = r_pred_ctr;
    assign bus.pred_u      = r_pred_u;
    assign bus.upd_ignored = r_upd_ignored;
endmodule

// File: tb/tb_tage_tagged_bank.sv
// Bench for tage_tagged_bank: behavioural table model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_tage_tagged_bank;
    localparam int IL = 4, TAG_LEN = 8, CTR_W = 3, U_W = 2, AGE_LOG = 3;
    localparam int N = 1 << IL, AGE_N = 1 << AGE_LOG;
    localparam int CTR_MAX = (1 << CTR_W) - 1, CTR_MID = 1 << (CTR_W - 1), U_MAX = (1 << U_W) - 1;
    localparam int TRAIN = 0, ALLOC = 1, UINC = 2, UDEC = 3;

    logic CLK;
    logic reset;
    tage_tagged_bank_if #(.IL(IL), .TAG_LEN(TAG_LEN), .CTR_W(CTR_W), .U_W(U_W)) bus ();

    tage_tagged_bank #(.IL(IL), .TAG_LEN(TAG_LEN), .CTR_W(CTR_W), .U_W(U_W), .AGE_LOG(AGE_LOG)) dut (
        .CLK(CLK), .reset(reset), .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_vld [N];
    int  m_tag [N];
    int  m_ctr [N];
    int  m_u   [N];
    int  m_ready, m_busy, m_age;
    int  e_pv, e_hit, e_tk, e_wk, e_ctr, e_u, e_ign;
    bit  started = 0;

    always @(posedge CLK) begin
        if (!reset) begin
            started = 1;
            m_ready = 0; m_busy = N; m_age = 0;
            e_pv = 0; e_hit = 0; e_tk = 0; e_wk = 0; e_ctr = 0; e_u = 0; e_ign = 0;
            for (int i = 0; i < N; i++) begin
                m_vld[i] = 0; m_tag[i] = 0; m_ctr[i] = CTR_MID - 1; m_u[i] = 0;
            end
        end else if (started) begin
            e_pv = 0; e_ign = 0;
            if (!m_ready) begin
                m_busy--;
                if (m_busy == 0) m_ready = 1;
            end else begin
                if (bus.lookup_valid) begin
                    int li;
                    li    = int'(bus.lookup_index);
                    e_pv  = 1;
                    e_hit = (m_vld[li] == 1 && m_tag[li] == int'(bus.lookup_tag)) ? 1 : 0;
                    e_ctr = e_hit ? m_ctr[li] : 0;
                    e_tk  = (e_hit && m_ctr[li] >= CTR_MID) ? 1 : 0;
                    e_wk  = (e_hit && (m_ctr[li] == CTR_MID || m_ctr[li] == CTR_MID - 1)) ? 1 : 0;
                    e_u   = m_u[li];
                end
                if (bus.upd_valid) begin
                    int ui, tg, hit;
                    ui  = int'(bus.upd_index);
                    tg  = int'(bus.upd_tag);
                    hit = (m_vld[ui] == 1 && m_tag[ui] == tg) ? 1 : 0;
                    case (int'(bus.upd_op))
                        TRAIN: if (hit) m_ctr[ui] = bus.upd_taken ? ((m_ctr[ui] < CTR_MAX) ? m_ctr[ui] + 1 : CTR_MAX)
                                                                  : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
                               else e_ign = 1;
                        ALLOC: if (m_u[ui] == 0) begin
                                   m_vld[ui] = 1; m_tag[ui] = tg; m_u[ui] = 0;
                                   m_ctr[ui] = bus.upd_taken ? CTR_MID : CTR_MID - 1;
                               end else begin
                                   m_u[ui] = m_u[ui] - 1; e_ign = 1;
                               end
                        UINC:  if (hit) m_u[ui] = (m_u[ui] < U_MAX) ? m_u[ui] + 1 : U_MAX; else e_ign = 1;
                        default: if (hit) m_u[ui] = (m_u[ui] > 0) ? m_u[ui] - 1 : 0; else e_ign = 1;
                    endcase
                    m_age = (m_age + 1) % AGE_N;
                    if (m_age == 0) begin
                        for (int i = 0; i < N; i++) m_u[i] = m_u[i] / 2;
                        m_ready = 0; m_busy = N;
                    end
                end
            end
        end
    end

    // Compare every cycle once the first reset edge has defined the DUT
    always @(negedge CLK) begin
        if (started) begin
            chk("ready",       int'(bus.ready),       m_ready);
            chk("upd_ignored", int'(bus.upd_ignored), e_ign);
            chk("pred_valid",  int'(bus.pred_valid),  e_pv);
            chk("pred_hit",    int'(bus.pred_hit),    e_hit);
            chk("pred_taken",  int'(bus.pred_taken),  e_tk);
            chk("pred_weak",   int'(bus.pred_weak),   e_wk);
            chk("pred_ctr",    int'(bus.pred_ctr),    e_ctr);
            chk("pred_u",      int'(bus.pred_u),      e_u);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic lookup(input int idx, input int tag);
        wait_ready();
        bus.lookup_valid = 1'b1;
        bus.lookup_index = idx[IL-1:0];
        bus.lookup_tag   = tag[TAG_LEN-1:0];
        @(negedge CLK);
        bus.lookup_valid = 1'b0;
    endtask

    task automatic upd(input int op, input int idx, input int tag, input int tk);
        wait_ready();
        bus.upd_valid = 1'b1;
        bus.upd_op    = op[1:0];
        bus.upd_index = idx[IL-1:0];
        bus.upd_tag   = tag[TAG_LEN-1:0];
        bus.upd_taken = tk[0];
        @(negedge CLK);
        bus.upd_valid = 1'b0;
    endtask

    task automatic both(input int idx, input int ltag, input int op, input int utag);
        wait_ready();
        bus.lookup_valid = 1'b1;
        bus.lookup_index = idx[IL-1:0];
        bus.lookup_tag   = ltag[TAG_LEN-1:0];
        bus.upd_valid    = 1'b1;
        bus.upd_op       = op[1:0];
        bus.upd_index    = idx[IL-1:0];
        bus.upd_tag      = utag[TAG_LEN-1:0];
        bus.upd_taken    = 1'b0;
        @(negedge CLK);
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
    endtask

    task automatic count_busy(input string nm);
        int n = 0;
        while (!bus.ready && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, n, 16);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int tags [4];
        tags[0] = 'hA1; tags[1] = 'h22; tags[2] = 'h33; tags[3] = 'h44;
        reset = 1'b0;
        bus.lookup_valid = 1'b0; bus.lookup_index = '0; bus.lookup_tag = '0;
        bus.upd_valid = 1'b0; bus.upd_op = '0; bus.upd_index = '0; bus.upd_tag = '0; bus.upd_taken = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_pred_valid", int'(bus.pred_valid), 0);
        reset = 1'b1;
        count_busy("init_len");

        lookup(5, 'hA1);
        chk("lit_pv", int'(bus.pred_valid), 1);
        chk("lit_miss", int'(bus.pred_hit), 0);
        chk("lit_miss_ctr", int'(bus.pred_ctr), 0);
        chk("lit_miss_u", int'(bus.pred_u), 0);

        upd(ALLOC, 5, 'hA1, 1);
        chk("lit_alloc_ign", int'(bus.upd_ignored), 0);
        lookup(5, 'hA1);
        chk("lit_alloc_hit", int'(bus.pred_hit), 1);
        chk("lit_alloc_ctr", int'(bus.pred_ctr), 4);
        chk("lit_alloc_tk", int'(bus.pred_taken), 1);
        chk("lit_alloc_wk", int'(bus.pred_weak), 1);

        repeat (4) upd(TRAIN, 5, 'hA1, 1);
        lookup(5, 'hA1);
        chk("lit_train_ctr7", int'(bus.pred_ctr), 7);
        upd(TRAIN, 5, 'hA1, 1);
        chk("lit_sat_ign", int'(bus.upd_ignored), 0);
        upd(TRAIN, 5, 'h22, 1);
        chk("lit_train_miss_ign", int'(bus.upd_ignored), 1);
        @(negedge CLK);
        chk("lit_ign_pulse", int'(bus.upd_ignored), 0);
        lookup(5, 'hA1);
        chk("lit_unchanged_ctr", int'(bus.pred_ctr), 7);

        // 8th accepted update wraps the age counter
        upd(UDEC, 5, 'hA1, 0);
        chk("lit_age_ready_drop", int'(bus.ready), 0);
        n = 0;
        while (!bus.ready && n < 40) begin
            bus.lookup_valid = (n == 3);
            bus.lookup_index = 4'd5;
            bus.lookup_tag   = 8'hA1;
            @(negedge CLK);
            n++;
            if (n == 4) chk("lit_age_no_pv", int'(bus.pred_valid), 0);
        end
        bus.lookup_valid = 1'b0;
        chk("age_len", n, 16);

        repeat (3) upd(UINC, 5, 'hA1, 0);
        lookup(5, 'hA1);
        chk("lit_u3", int'(bus.pred_u), 3);
        upd(ALLOC, 5, 'h33, 1);
        chk("lit_alloc_busy_ign", int'(bus.upd_ignored), 1);
        lookup(5, 'hA1);
        chk("lit_tag_kept", int'(bus.pred_hit), 1);
        chk("lit_u2", int'(bus.pred_u), 2);
        both(5, 'hA1, UDEC, 'hA1);
        chk("lit_rbw_old_u", int'(bus.pred_u), 2);
        lookup(5, 'hA1);
        chk("lit_rbw_new_u", int'(bus.pred_u), 1);
        repeat (2) upd(UINC, 5, 'hA1, 0);
        lookup(5, 'hA1);
        chk("lit_u3_again", int'(bus.pred_u), 3);
        upd(TRAIN, 5, 'hA1, 1);
        wait_ready();
        lookup(5, 'hA1);
        chk("lit_aged_u1", int'(bus.pred_u), 1);

        // randomized traffic, including requests while not ready
        for (int c = 0; c < 600; c++) begin
            bus.lookup_valid = 1'($urandom_range(0, 1));
            bus.lookup_index = 4'($urandom_range(0, 3));
            bus.lookup_tag   = tags[$urandom_range(0, 3)][TAG_LEN-1:0];
            bus.upd_valid    = 1'($urandom_range(0, 1));
            bus.upd_op       = 2'($urandom_range(0, 3));
            bus.upd_index    = 4'($urandom_range(0, 3));
            bus.upd_tag      = tags[$urandom_range(0, 3)][TAG_LEN-1:0];
            bus.upd_taken    = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;

        // force an aging sweep, then reset in the middle of it
        wait_ready();
        n = 0;
        bus.upd_op = 2'(UINC); bus.upd_index = '0; bus.upd_tag = '0;
        while (bus.ready && n < 20) begin
            bus.upd_valid = 1'b1;
            @(negedge CLK);
            n++;
        end
        bus.upd_valid = 1'b0;
        chk("age_entered", int'(bus.ready), 0);
        repeat (7) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        count_busy("reinit_len");
        for (int i = 0; i < N; i++) begin
            lookup(i, 'hA1);
            if (i == 5) begin
                chk("lit_reinit_miss", int'(bus.pred_hit), 0);
                chk("lit_reinit_u0", int'(bus.pred_u), 0);
            end
        end
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
